// File: rtl/risc_mem_arbiter_if.sv
// Bus bundle between the RISC_TOY core ports, the arbiter and the shared single-port SRAM.
// Handshake: a request (I_REQ/D_REQ) is taken in any cycle its STALL is low; while STALL is
// high the requester holds REQ and its address/data stable. VALID follows each grant by one cycle.
interface risc_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int BW = 32
);
  logic          I_REQ;
  logic [29:0]   I_ADDR;
  logic          I_STALL;
  logic          I_VALID;
  logic [BW-1:0] I_RDATA;

  logic          D_REQ;
  logic          D_WE;
  logic [29:0]   D_ADDR;
  logic [BW-1:0] D_WDATA;
  logic          D_STALL;
  logic          D_VALID;
  logic [BW-1:0] D_RDATA;

  logic          M_CSN;
  logic          M_WEN;
  logic [AW-1:0] M_A;
  logic [BW-1:0] M_DI;
  logic [BW-1:0] M_DOUT;

  // arbiter side
  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, M_DOUT,
    output I_STALL, I_VALID, I_RDATA, D_STALL, D_VALID, D_RDATA,
    output M_CSN, M_WEN, M_A, M_DI
  );

  // core + SRAM side
  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, M_DOUT,
    input  I_STALL, I_VALID, I_RDATA, D_STALL, D_VALID, D_RDATA,
    input  M_CSN, M_WEN, M_A, M_DI
  );
endinterface

// File: rtl/risc_mem_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and data access: data has fixed
// priority, bounded by a streak counter that forces an instruction grant.
module risc_mem_arbiter #(
  parameter int AW          = 10,
  parameter int BW          = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                CLK,
  input  logic                RSTN,
  risc_mem_arbiter_if.slave   bus,
  output logic [1:0]          dbg_owner,
  output logic [3:0]          dbg_streak
);

  typedef enum logic [1:0] {
    O_NONE = 2'd0,
    O_I    = 2'd1,
    O_D_RD = 2'd2,
    O_D_WR = 2'd3
  } owner_e;

  owner_e     owner, owner_nxt;
  logic [3:0] streak, streak_nxt;

  logic i_req, d_req, force_i, grant_i, grant_d;

  // Requests are masked during reset so the SRAM stays idle while RSTN is low.
  assign i_req   = bus.I_REQ & RSTN;
  assign d_req   = bus.D_REQ & RSTN;
  assign force_i = (streak == 4'(MAX_DSTREAK));
  assign grant_d = d_req & ~(i_req & force_i);
  assign grant_i = i_req & ~grant_d;

  assign bus.I_STALL = i_req & ~grant_i;
  assign bus.D_STALL = d_req & ~grant_d;

  // Upper address bits alias onto the SRAM and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{bus.I_ADDR[29:AW], bus.D_ADDR[29:AW]};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      owner  <= O_NONE;
      streak <= 4'd0;
    end else begin
      owner  <= owner_nxt;
      streak <= streak_nxt;
    end
  end

  always_comb begin
    owner_nxt  = O_NONE;
    streak_nxt = streak;
    bus.M_CSN  = 1'b1;
    bus.M_WEN  = 1'b1;
    bus.M_A    = '0;
    bus.M_DI   = '0;

    if (grant_d) begin
      bus.M_CSN = 1'b0;
      bus.M_WEN = ~bus.D_WE;
      bus.M_A   = bus.D_ADDR[AW-1:0];
      bus.M_DI  = bus.D_WDATA;
      owner_nxt = bus.D_WE ? O_D_WR : O_D_RD;
    end else if (grant_i) begin
      bus.M_CSN = 1'b0;
      bus.M_A   = bus.I_ADDR[AW-1:0];
      owner_nxt = O_I;
    end

    // Streak counts data wins only while a fetch is actually waiting.
    if (grant_i || !i_req) begin
      streak_nxt = 4'd0;
    end else if (grant_d && (streak < 4'(MAX_DSTREAK))) begin
      streak_nxt = streak + 4'd1;
    end
  end

  assign bus.I_VALID = (owner == O_I);
  assign bus.D_VALID = (owner == O_D_RD) || (owner == O_D_WR);
  assign bus.I_RDATA = (owner == O_I)    ? bus.M_DOUT : '0;
  assign bus.D_RDATA = (owner == O_D_RD) ? bus.M_DOUT : '0;

  assign dbg_owner  = owner;
  assign dbg_streak = streak;

endmodule

// File: tb/tb_risc_mem_arbiter.sv
// Directed bench for risc_mem_arbiter with a behavioural 1-cycle-latency SRAM model.
module tb_risc_mem_arbiter;

  localparam int AW = 10;
  localparam int BW = 32;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_owner;
  logic [3:0] dbg_streak;
  int         total;
  int         bad;

  risc_mem_arbiter_if #(.AW(AW), .BW(BW)) bus ();

  risc_mem_arbiter #(.AW(AW), .BW(BW), .MAX_DSTREAK(4)) dut (
    .CLK        (clk),
    .RSTN       (rst_n),
    .bus        (bus),
    .dbg_owner  (dbg_owner),
    .dbg_streak (dbg_streak)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: write on WEN=0, otherwise registered read
  logic [BW-1:0] mem [1024];
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[3] = 32'hA5A5_0001;
    bus.M_DOUT = '0;
  end
  always @(posedge clk) begin
    if (!bus.M_CSN) begin
      if (!bus.M_WEN) mem[bus.M_A] <= bus.M_DI;
      else            bus.M_DOUT   <= mem[bus.M_A];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [29:0] iaddr,
                       input logic dreq, input logic dwe,
                       input logic [29:0] daddr, input logic [31:0] wdata);
    bus.I_REQ   = ireq;
    bus.I_ADDR  = iaddr;
    bus.D_REQ   = dreq;
    bus.D_WE    = dwe;
    bus.D_ADDR  = daddr;
    bus.D_WDATA = wdata;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // 1. reset then idle
    to_neg();
    to_neg();
    chk("rst_owner", 64'(dbg_owner), 64'd0);
    chk("rst_streak", 64'(dbg_streak), 64'd0);
    chk("rst_csn", 64'(bus.M_CSN), 64'd1);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      to_pos();
      chk("idle_csn", 64'(bus.M_CSN), 64'd1);
      chk("idle_wen", 64'(bus.M_WEN), 64'd1);
      chk("idle_stall", 64'({bus.I_STALL, bus.D_STALL}), 64'd0);
      chk("idle_valid", 64'({bus.I_VALID, bus.D_VALID}), 64'd0);
      chk("idle_rdata", 64'({bus.I_RDATA, bus.D_RDATA}), 64'd0);
    end

    // 2. lone fetch of word 3
    to_neg();
    drive(1'b1, 30'h3, 1'b0, 1'b0, '0, '0);
    #1;
    chk("fetch_csn", 64'(bus.M_CSN), 64'd0);
    chk("fetch_a", 64'(bus.M_A), 64'h3);
    chk("fetch_wen", 64'(bus.M_WEN), 64'd1);
    chk("fetch_istall", 64'(bus.I_STALL), 64'd0);
    to_pos();
    chk("fetch_ivalid", 64'(bus.I_VALID), 64'd1);
    chk("fetch_irdata", 64'(bus.I_RDATA), 64'hA5A5_0001);
    chk("fetch_dvalid", 64'(bus.D_VALID), 64'd0);
    to_neg();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    to_pos();
    chk("fetch_ivalid_off", 64'(bus.I_VALID), 64'd0);
    chk("fetch_irdata_off", 64'(bus.I_RDATA), 64'd0);

    // 3. store then load (load address aliases onto 0x10)
    to_neg();
    drive(1'b0, '0, 1'b1, 1'b1, 30'h10, 32'hDEADBEEF);
    #1;
    chk("st_csn", 64'(bus.M_CSN), 64'd0);
    chk("st_wen", 64'(bus.M_WEN), 64'd0);
    chk("st_a", 64'(bus.M_A), 64'h10);
    chk("st_di", 64'(bus.M_DI), 64'hDEADBEEF);
    to_pos();
    chk("st_owner", 64'(dbg_owner), 64'd3);
    to_neg();
    drive(1'b0, '0, 1'b1, 1'b0, 30'h410, 32'h0);
    #1;
    chk("st_dvalid", 64'(bus.D_VALID), 64'd1);
    chk("st_drdata", 64'(bus.D_RDATA), 64'd0);
    chk("ld_wen", 64'(bus.M_WEN), 64'd1);
    chk("ld_alias_a", 64'(bus.M_A), 64'h10);
    chk("ld_di", 64'(bus.M_DI), 64'd0);
    to_pos();
    chk("ld_dvalid", 64'(bus.D_VALID), 64'd1);
    chk("ld_drdata", 64'(bus.D_RDATA), 64'hDEADBEEF);
    to_neg();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // 4. conflict: data first, fetch next cycle
    to_neg();
    drive(1'b1, 30'h3, 1'b1, 1'b0, 30'h10, '0);
    #1;
    chk("cf_istall", 64'(bus.I_STALL), 64'd1);
    chk("cf_dstall", 64'(bus.D_STALL), 64'd0);
    chk("cf_a_data", 64'(bus.M_A), 64'h10);
    to_pos();
    chk("cf_dvalid", 64'(bus.D_VALID), 64'd1);
    chk("cf_drdata", 64'(bus.D_RDATA), 64'hDEADBEEF);
    chk("cf_streak1", 64'(dbg_streak), 64'd1);
    to_neg();
    drive(1'b1, 30'h3, 1'b0, 1'b0, '0, '0);
    #1;
    chk("cf_istall_rel", 64'(bus.I_STALL), 64'd0);
    chk("cf_a_inst", 64'(bus.M_A), 64'h3);
    to_pos();
    chk("cf_ivalid", 64'(bus.I_VALID), 64'd1);
    chk("cf_dvalid_off", 64'(bus.D_VALID), 64'd0);
    chk("cf_irdata", 64'(bus.I_RDATA), 64'hA5A5_0001);
    chk("cf_streak0", 64'(dbg_streak), 64'd0);

    // 5. both held: D,D,D,D,I repeating, streak 0..4
    to_neg();
    drive(1'b1, 30'h3, 1'b1, 1'b0, 30'h10, '0);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("sv_streak", 64'(dbg_streak), 64'(k % 5));
      chk("sv_istall", 64'(bus.I_STALL), 64'((k % 5) != 4));
      chk("sv_dstall", 64'(bus.D_STALL), 64'((k % 5) == 4));
      to_pos();
      chk("sv_ivalid", 64'(bus.I_VALID), 64'((k % 5) == 4));
      chk("sv_dvalid", 64'(bus.D_VALID), 64'((k % 5) != 4));
      to_neg();
    end
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    to_pos();
    chk("sv_streak_clr", 64'(dbg_streak), 64'd0);

    // 6. reset pulsed while a data read is outstanding
    to_neg();
    drive(1'b1, 30'h3, 1'b1, 1'b0, 30'h10, '0);
    to_pos();
    chk("rr_owner_rd", 64'(dbg_owner), 64'd2);
    chk("rr_streak1", 64'(dbg_streak), 64'd1);
    rst_n = 1'b0;
    bus.I_REQ = 1'b0;
    #1;
    chk("rr_dvalid_rst", 64'(bus.D_VALID), 64'd0);
    chk("rr_owner_rst", 64'(dbg_owner), 64'd0);
    chk("rr_streak_rst", 64'(dbg_streak), 64'd0);
    chk("rr_csn_masked", 64'(bus.M_CSN), 64'd1);
    chk("rr_dstall_masked", 64'(bus.D_STALL), 64'd0);
    to_neg();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    to_pos();
    chk("rr_dvalid_after", 64'(bus.D_VALID), 64'd0);
    chk("rr_owner_after", 64'(dbg_owner), 64'd0);
    chk("rr_streak_after", 64'(dbg_streak), 64'd0);
    to_pos();
    chk("rr_dvalid_after2", 64'(bus.D_VALID), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
